// File: rtl/prv_counter_pkg.sv
// Shared types for the priRV32 general-purpose timer/counter.
package prv_counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10
    } cnt_mode_e;

    typedef enum logic {
        CNT_RUN,
        CNT_HALT
    } cnt_state_e;

    // The reserved encoding 2'b11 behaves as wrap.
    function automatic cnt_mode_e decode_mode(logic [1:0] m);
        case (m)
            2'b01:   return CNT_SAT;
            2'b10:   return CNT_ONESHOT;
            default: return CNT_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/prv_prescaler.sv
// Clock prescaler: one tick every (prescale + 1) enabled cycles.
module prv_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic                  hit;

    assign hit = (psc_q == prescale);

    always_comb begin
        psc_d = psc_q;
        if (clear) begin
            psc_d = '0;
        end else if (enable) begin
            psc_d = hit ? '0 : psc_q + PRESCALE_W'(1);
        end
    end

    // A clear (load) consumes the cycle, so no tick alongside it.
    assign tick = enable & hit & ~clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/prv_timer_counter.sv
// General-purpose timer: prescaled up/down counter with wrap, saturate and
// one-shot modes, compare match and a sticky interrupt flag.
module prv_timer_counter
    import prv_counter_pkg::*;
#(
    parameter int unsigned     WIDTH      = 8,
    parameter int unsigned     PRESCALE_W = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  irq_clr,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  cmp_match,
    output logic                  irq,
    output logic                  busy
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             cmp_q, cmp_d;
    logic             irq_q, irq_d;
    logic             tick;

    cnt_mode_e        mode_e;
    logic [WIDTH-1:0] term_val, start_val, step_val, load_clamped;
    logic             at_term;

    prv_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (load),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CNT_RUN;
            out_q   <= RESET_VAL;
            tc_q    <= 1'b0;
            cmp_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tc_q    <= tc_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        mode_e       = decode_mode(mode);
        term_val     = up_down ? limit : '0;
        start_val    = up_down ? '0 : limit;
        // Counting up past a lowered limit counts as having reached it.
        at_term      = up_down ? (out_q >= limit) : (out_q == '0);
        step_val     = up_down ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
        load_clamped = (load_val > limit) ? limit : load_val;

        state_d = state_q;
        out_d   = out_q;
        tc_d    = 1'b0;
        cmp_d   = 1'b0;

        if (load) begin
            out_d   = load_clamped;
            state_d = CNT_RUN;
            cmp_d   = (load_clamped == cmp_val);
        end else if (tick && state_q == CNT_RUN) begin
            unique case (mode_e)
                CNT_SAT: begin
                    if (at_term) begin
                        out_d = term_val;
                    end else begin
                        out_d = step_val;
                        tc_d  = (step_val == term_val);
                    end
                end
                CNT_ONESHOT: begin
                    if (at_term) begin
                        out_d   = term_val;
                        tc_d    = 1'b1;
                        state_d = CNT_HALT;
                    end else begin
                        out_d = step_val;
                        tc_d  = (step_val == term_val);
                        if (tc_d) begin
                            state_d = CNT_HALT;
                        end
                    end
                end
                default: begin
                    if (at_term) begin
                        out_d = start_val;
                        tc_d  = 1'b1;
                    end else begin
                        out_d = step_val;
                    end
                end
            endcase
            // A held value must not re-fire the compare.
            cmp_d = (out_d == cmp_val) && (out_d != out_q);
        end

        irq_d = tc_d | cmp_d | (irq_q & ~irq_clr);
    end

    always_comb begin
        out       = out_q;
        tc        = tc_q;
        cmp_match = cmp_q;
        irq       = irq_q;
        busy      = (state_q == CNT_RUN);
    end

endmodule

// File: tb/tb_prv_timer_counter.sv
// Directed, table-driven bench for prv_timer_counter (WIDTH 8, PRESCALE_W 4).
module tb_prv_timer_counter;

    localparam logic [7:0] RV = 8'h03;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ud;
        logic [1:0] md;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] lim;
        logic [3:0] ps;
        logic [7:0] cv;
        logic       clr;
        logic [7:0] e_out;
        logic       e_tc;
        logic       e_cmp;
        logic       e_irq;
        logic       e_busy;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [7:0] cmp_val;
    logic       irq_clr;
    logic [7:0] out;
    logic       tc;
    logic       cmp_match;
    logic       irq;
    logic       busy;

    int checks = 0;
    int errors = 0;

    prv_timer_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4),
        .RESET_VAL  (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .limit     (limit),
        .prescale  (prescale),
        .cmp_val   (cmp_val),
        .irq_clr   (irq_clr),
        .out       (out),
        .tc        (tc),
        .cmp_match (cmp_match),
        .irq       (irq),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic en, logic ud, logic [1:0] md, logic ld,
                                logic [7:0] lv, logic [7:0] lim, logic [3:0] ps,
                                logic [7:0] cv, logic clr, logic [7:0] eo, logic etc,
                                logic ecmp, logic eirq, logic ebusy);
        vec_t v;
        v.rst = rst; v.en = en; v.ud = ud; v.md = md; v.ld = ld; v.lv = lv;
        v.lim = lim; v.ps = ps; v.cv = cv; v.clr = clr;
        v.e_out = eo; v.e_tc = etc; v.e_cmp = ecmp; v.e_irq = eirq; v.e_busy = ebusy;
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge consume them, then compare.
    task automatic apply(input vec_t v, input string name);
        reset    = v.rst;
        enable   = v.en;
        up_down  = v.ud;
        mode     = v.md;
        load     = v.ld;
        load_val = v.lv;
        limit    = v.lim;
        prescale = v.ps;
        cmp_val  = v.cv;
        irq_clr  = v.clr;
        @(posedge clk);
        #1;
        checks++;
        if (out !== v.e_out || tc !== v.e_tc || cmp_match !== v.e_cmp ||
            irq !== v.e_irq || busy !== v.e_busy) begin
            errors++;
            $display("FAIL %s: got out=%0d tc=%0b cmp=%0b irq=%0b busy=%0b, want out=%0d tc=%0b cmp=%0b irq=%0b busy=%0b",
                     name, out, tc, cmp_match, irq, busy,
                     v.e_out, v.e_tc, v.e_cmp, v.e_irq, v.e_busy);
        end
    endtask

    vec_t vecs[$];
    int   en_seq[18]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int   out_seq[18] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3};

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; mode = 2'b00; load = 1'b0;
        load_val = '0; limit = '0; prescale = '0; cmp_val = '0; irq_clr = 1'b0;
        @(posedge clk);
        #1;

        //            rst en ud md ld lv    lim    ps cv     clr  out  tc cm irq busy
        // Reset, then wrap up with limit 5
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   RV,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,     5,     0, 8'hFF, 0,   0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   1,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   2,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   3,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   4,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   5,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   0,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   1,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 1,   2,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     5,     0, 8'hFF, 0,   3,   0, 0, 0, 1));
        // Down saturate from 3
        vecs.push_back(mk(0, 1, 0, 1, 1, 3,     5,     0, 8'hFF, 0,   3,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,     5,     0, 8'hFF, 0,   2,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,     5,     0, 8'hFF, 0,   1,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,     5,     0, 8'hFF, 0,   0,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,     5,     0, 8'hFF, 0,   0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,     5,     0, 8'hFF, 0,   0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,     5,     0, 8'hFF, 1,   0,   0, 0, 0, 1));
        // Compare, set-beats-clear, load clamp, load compare, freeze
        vecs.push_back(mk(0, 1, 1, 0, 1, 5,     200,   0, 7,     0,   5,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     200,   0, 7,     0,   6,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     200,   0, 7,     1,   7,   0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     200,   0, 7,     0,   8,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 250,   200,   0, 7,     0,   200, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 7,     200,   0, 7,     1,   7,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,     200,   0, 7,     1,   7,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,     200,   0, 7,     0,   7,   0, 0, 0, 1));
        // Saturated at 7 == cmp_val: no repeated compare, no tc
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,     7,     0, 7,     0,   7,   0, 0, 0, 1));
        // Limit lowered below out in wrap: treated as terminal
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     4,     0, 8'hFF, 0,   0,   1, 0, 1, 1));
        // Limit 0: wrap ticks tc each time, one-shot halts on first tick
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,     0,     0, 8'hFF, 1,   0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     0,     0, 8'hFF, 0,   0,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,     0,     0, 8'hFF, 0,   0,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 2, 1, 0,     0,     0, 8'hFF, 1,   0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 0, 0,     0,     0, 8'hFF, 0,   0,   1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2, 0, 0,     0,     0, 8'hFF, 0,   0,   0, 0, 1, 0));
        // Down wrap reloads limit; reserved mode 11 wraps
        vecs.push_back(mk(0, 1, 0, 0, 1, 2,     3,     0, 8'hFF, 0,   2,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,     3,     0, 8'hFF, 0,   1,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,     3,     0, 8'hFF, 0,   0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,     3,     0, 8'hFF, 0,   3,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 0,     3,     0, 8'hFF, 0,   0,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 0,     3,     0, 8'hFF, 0,   1,   0, 0, 1, 1));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Prescale 3 with a 6-cycle freeze in the middle
        apply(mk(0, 1, 1, 0, 1, 0, 200, 3, 8'hFF, 1, 0, 0, 0, 0, 1), "psc_load");
        for (int i = 0; i < 18; i++) begin
            apply(mk(0, en_seq[i][0], 1, 0, 0, 0, 200, 3, 8'hFF, 0,
                     8'(out_seq[i]), 0, 0, 0, 1), $sformatf("psc%0d", i));
        end

        // One-shot to 4, hold for 10 ticks, then reload resumes counting
        apply(mk(0, 1, 1, 2, 1, 0, 4, 0, 8'hFF, 1, 0, 0, 0, 0, 1), "os_load");
        for (int i = 1; i <= 4; i++) begin
            apply(mk(0, 1, 1, 2, 0, 0, 4, 0, 8'hFF, 0, 8'(i), (i == 4), 0, (i == 4), (i != 4)),
                  $sformatf("os_up%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            apply(mk(0, 1, 1, 2, 0, 0, 4, 0, 8'hFF, 0, 4, 0, 0, 1, 0), $sformatf("os_hold%0d", i));
        end
        apply(mk(0, 1, 1, 2, 1, 0, 4, 0, 8'hFF, 0, 0, 0, 0, 1, 1), "os_reload");
        apply(mk(0, 1, 1, 2, 0, 0, 4, 0, 8'hFF, 0, 1, 0, 0, 1, 1), "os_resume");

        // Reset wins over a simultaneous load mid-count
        apply(mk(0, 1, 1, 0, 1, 9, 200, 0, 9, 0, 9, 0, 1, 1, 1), "rst_pre");
        apply(mk(1, 1, 1, 0, 1, 50, 200, 0, 9, 0, RV, 0, 0, 0, 1), "rst_mid");
        apply(mk(0, 1, 1, 0, 0, 0, 200, 0, 8'hFF, 0, RV + 8'd1, 0, 0, 0, 1), "rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
